// File: rtl/shift_req_queue.sv
// shift_req_queue: small request FIFO feeding a combinational barrel shifter,
// with a registered, back-pressurable result stage and a saturating
// completion counter.
module shift_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [2:0]               in_amount,
    input  logic                     in_dir,
    output logic [7:0]               shf_data_in,
    output logic [2:0]               shf_shift_amount,
    output logic                     shf_shift_direction,
    input  logic [7:0]               shf_data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              done_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] amount;
        logic       dir;
    } req_t;

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [LW-1:0]   level_q,      level_d;
    logic            out_valid_q,  out_valid_d;
    logic [7:0]      out_data_q,   out_data_d;
    logic [15:0]     done_count_q, done_count_d;

    logic            push_s;
    logic            pop_s;
    logic            in_ready_s;
    logic            not_empty_s;
    logic            handoff_s;
    req_t            head_s;
    req_t            wr_entry_s;

    // Handshake qualifiers; in_ready looks at occupancy only, never at out_ready.
    always_comb begin
        not_empty_s = (level_q != LVL_ZERO);
        in_ready_s  = (level_q < LVL_FULL);
        push_s      = in_valid && in_ready_s;
        pop_s       = not_empty_s && (!out_valid_q || out_ready);
        handoff_s   = out_valid_q && out_ready;
        head_s      = mem_q[rd_ptr_q];
        wr_entry_s  = '{data: in_data, amount: in_amount, dir: in_dir};
    end

    // Shifter drive from the head entry, forced to zero when the queue is empty.
    always_comb begin
        shf_data_in         = 8'h00;
        shf_shift_amount    = 3'd0;
        shf_shift_direction = 1'b0;
        if (not_empty_s) begin
            shf_data_in         = head_s.data;
            shf_shift_amount    = head_s.amount;
            shf_shift_direction = head_s.dir;
        end else begin
            shf_data_in         = 8'h00;
            shf_shift_amount    = 3'd0;
            shf_shift_direction = 1'b0;
        end
    end

    // Next-state for pointers, occupancy, result register and completion counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        done_count_d = done_count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A pop refills the result register even while it is being drained.
        if (pop_s) begin
            out_valid_d = 1'b1;
            out_data_d  = shf_data_out;
        end else if (handoff_s) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end

        if (handoff_s && (done_count_q != CNT_MAX)) begin
            done_count_d = done_count_q + 16'd1;
        end else begin
            done_count_d = done_count_q;
        end
    end

    // Control and result state, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= LVL_ZERO;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            done_count_q <= 16'h0000;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            done_count_q <= done_count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign level      = level_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_shift_req_queue.sv
// Bench for shift_req_queue: a behavioural barrel shifter closes the loop,
// and a scoreboard queue holds expected results in acceptance order.
module tb_shift_req_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_amount;
    logic        in_dir;
    logic [7:0]  shf_data_in;
    logic [2:0]  shf_shift_amount;
    logic        shf_shift_direction;
    logic [7:0]  shf_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic [15:0] done_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    function automatic logic [7:0] shf_model(input logic [7:0] d, input logic [2:0] a, input logic dir);
        return dir ? (d >> a) : (d << a);
    endfunction

    assign shf_data_out = shf_model(shf_data_in, shf_shift_amount, shf_shift_direction);

    shift_req_queue #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_amount           (in_amount),
        .in_dir              (in_dir),
        .shf_data_in         (shf_data_in),
        .shf_shift_amount    (shf_shift_amount),
        .shf_shift_direction (shf_shift_direction),
        .shf_data_out        (shf_data_out),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .level               (level),
        .done_count          (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every result handed off must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got out_data=%02h, expected no result", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %02h, expected %02h", out_data, e);
                end
            end
        end
        if (rst_n && level == 3'd0) begin
            checks++;
            if ({shf_data_in, shf_shift_amount, shf_shift_direction} !== 12'h000) begin
                errors++;
                $display("FAIL shf_empty_zero: got %03h, expected 000",
                         {shf_data_in, shf_shift_amount, shf_shift_direction});
            end
        end
    end

    // Present one request starting at posedge+1, hold until accepted; returns at posedge+1.
    task automatic push_req(input logic [7:0] d, input logic [2:0] a, input logic dir, input logic [7:0] e);
        bit ok;
        ok = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_dir    = dir;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%0b, expected 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amount = 3'd0;
        in_dir    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d out_valid=%0b, expected 0/0", name, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        #3;
        checks++;
        if ({level, out_valid, out_data, in_ready, done_count} !== {3'd0, 1'b0, 8'h00, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_initial: level=%0d ov=%0b od=%02h ir=%0b dc=%0d, expected 0 0 00 1 0",
                     level, out_valid, out_data, in_ready, done_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Four pushes with out_ready low: one in the result register, three queued.
        push_req(8'h11, 3'd0, 1'b0, 8'h11);
        push_req(8'h22, 3'd0, 1'b0, 8'h22);
        push_req(8'h33, 3'd0, 1'b0, 8'h33);
        push_req(8'h44, 3'd0, 1'b0, 8'h44);
        idle_inputs();
        checks++;
        if (level !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: level=%0d ov=%0b, expected 3 1", level, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({level, out_valid, out_data, in_ready, done_count} !== {3'd0, 1'b0, 8'h00, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_async: level=%0d ov=%0b od=%02h ir=%0b dc=%0d, expected 0 0 00 1 0",
                     level, out_valid, out_data, in_ready, done_count);
        end
        checks++;
        if ({shf_data_in, shf_shift_amount, shf_shift_direction} !== 12'h000) begin
            errors++;
            $display("FAIL reset_shf: got %03h, expected 000", {shf_data_in, shf_shift_amount, shf_shift_direction});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_req(8'hCC, 3'd0, 1'b0, 8'hCC);
        idle_inputs();
        checks++;
        if (level !== 3'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after_e0: level=%0d ov=%0b, expected 1 0", level, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hCC || level !== 3'd0) begin
            errors++;
            $display("FAIL single_after_e1: ov=%0b od=%02h level=%0d, expected 1 cc 0", out_valid, out_data, level);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_count !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after_e2: dc=%0d ov=%0b, expected 1 0", done_count, out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [7:0]  d   [4] = '{8'h3C, 8'h3C, 8'h18, 8'hF0};
        logic [2:0]  a   [4] = '{3'd2, 3'd2, 3'd3, 3'd4};
        logic        r   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0]  e   [4] = '{8'hF0, 8'h0F, 8'hC0, 8'h0F};
        logic [15:0] dc0;
        dc0 = done_count;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(d[i], a[i], r[i], e[i]);
            checks++;
            if (level > 3'd1) begin
                errors++;
                $display("FAIL stream_level: level=%0d, expected <=1", level);
            end
        end
        idle_inputs();
        // Results of the 3rd and 4th pushes must follow without a bubble.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_consecutive: ov=%0b at tail cycle %0d, expected 1", out_valid, i);
            end
            @(posedge clk);
            #1;
        end
        wait_drain("stream");
        checks++;
        if (done_count !== dc0 + 16'd4) begin
            errors++;
            $display("FAIL stream_count: dc=%0d, expected %0d", done_count, dc0 + 16'd4);
        end
    endtask

    task automatic test_backpressure();
        int          accepted;
        int          idx;
        logic [7:0]  held;
        logic [15:0] dc0;
        dc0 = done_count;
        accepted = 0;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid  = (idx < 6);
            in_data   = 8'h01 << idx[2:0];
            in_amount = 3'd1;
            in_dir    = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(8'h02 << idx[2:0]);
                accepted++;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (accepted != DEPTH + 1) begin
            errors++;
            $display("FAIL bp_accepted: got %0d, expected %0d", accepted, DEPTH + 1);
        end
        checks++;
        if (level !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: level=%0d ir=%0b ov=%0b, expected 4 0 1", level, in_ready, out_valid);
        end
        held = out_data;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_data !== held || out_valid !== 1'b1 || out_data !== 8'h02) begin
            errors++;
            $display("FAIL bp_stall_stable: od=%02h ov=%0b, expected 02 1", out_data, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full_pop: ir=%0b, expected 0", in_ready);
        end
        idle_inputs();
        wait_drain("bp");
        checks++;
        if (done_count !== dc0 + 16'd5) begin
            errors++;
            $display("FAIL bp_count: dc=%0d, expected %0d", done_count, dc0 + 16'd5);
        end
    endtask

    task automatic test_wrap();
        int          sent;
        int          n;
        logic [7:0]  d;
        logic [2:0]  a;
        logic        r;
        do_reset();
        sent = 0;
        n = 0;
        d = 8'h00;
        a = 3'd0;
        r = 1'b0;
        while ((sent < 10 || exp_q.size() != 0 || out_valid) && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 10 && !in_valid) begin
                d = 8'($urandom_range(0, 255));
                a = 3'($urandom_range(0, 7));
                r = 1'($urandom_range(0, 1));
                in_valid  = 1'b1;
                in_data   = d;
                in_amount = a;
                in_dir    = r;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(shf_model(d, a, r));
                sent++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        idle_inputs();
        checks++;
        if (sent != 10 || exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_complete: sent=%0d pending=%0d ov=%0b, expected 10 0 0", sent, exp_q.size(), out_valid);
        end
        checks++;
        if (done_count !== 16'd10) begin
            errors++;
            $display("FAIL wrap_count: dc=%0d, expected 10", done_count);
        end
    endtask

    task automatic test_push_pop_level2();
        out_ready = 1'b0;
        push_req(8'h05, 3'd1, 1'b0, 8'h0A);
        push_req(8'h06, 3'd1, 1'b0, 8'h0C);
        push_req(8'h07, 3'd1, 1'b0, 8'h0E);
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL pp_pre_level: level=%0d, expected 2", level);
        end
        out_ready = 1'b1;
        push_req(8'h40, 3'd2, 1'b1, 8'h10);
        idle_inputs();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_level2: level=%0d ir=%0b, expected 2 1", level, in_ready);
        end
        out_ready = 1'b1;
        wait_drain("pp");
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_push_pop_level2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
